// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetcher and LSB onto the
// 8-bit RAM/IO bus, assembling and splitting little-endian words.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ena_from_if,
    input  logic [31:0] pc_from_if,
    input  logic        drop_flag_from_if,
    output logic        ok_flag_to_if,
    output logic [31:0] inst_to_if,
    input  logic        ena_from_lsb,
    input  logic        wr_flag_from_lsb,
    input  logic [31:0] addr_from_lsb,
    input  logic [2:0]  size_from_lsb,
    input  logic [31:0] data_from_lsb,
    output logic        ok_flag_to_lsb,
    output logic [31:0] data_to_lsb,
    input  logic        rollback_flag_from_rob,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state;
    logic        pend_if;
    logic        pend_ls;
    logic [31:0] if_pc;
    logic [31:0] ls_addr;
    logic [31:0] ls_data;
    logic [2:0]  ls_size;
    logic        ls_wr;
    logic        src_ls;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [31:0] shift_data;
    logic [31:0] rbuf;
    logic [1:0]  lane;
    logic [31:0] word;
    logic        live_if;
    logic        live_ls;
    logic        io_stall;
    logic        take_ls;
    logic        take_if;
    logic        abort;
    logic        done_rd;
    logic        done_wr;

    // A rollback only cancels loads; committed stores always go out.
    assign live_if  = pend_if & ~drop_flag_from_if;
    assign live_ls  = pend_ls & ~(rollback_flag_from_rob & ~ls_wr);
    assign io_stall = ls_wr & (ls_addr[17:16] == 2'b11) & io_buffer_full;
    assign take_ls  = (state == IDLE) & live_ls & ~io_stall;
    assign take_if  = (state == IDLE) & ~pend_ls & live_if;
    assign abort    = (state == READ) &
                      (src_ls ? rollback_flag_from_rob : drop_flag_from_if);
    assign done_rd  = (cnt == len + 3'd1);
    assign done_wr  = (cnt == len);
    assign lane     = cnt[1:0] - 2'd2;

    // Read data lags the address by one cycle, so the byte in flight on
    // edge k belongs to lane k-2.
    always_comb begin
        word = rbuf;
        word[8*lane +: 8] = mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pend_if        <= 1'b0;
            pend_ls        <= 1'b0;
            if_pc          <= '0;
            ls_addr        <= '0;
            ls_data        <= '0;
            ls_size        <= '0;
            ls_wr          <= 1'b0;
            src_ls         <= 1'b0;
            cnt            <= '0;
            len            <= '0;
            shift_data     <= '0;
            rbuf           <= '0;
            ok_flag_to_if  <= 1'b0;
            ok_flag_to_lsb <= 1'b0;
            inst_to_if     <= '0;
            data_to_lsb    <= '0;
            mem_a          <= '0;
            mem_dout       <= '0;
            mem_wr         <= 1'b0;
        end else if (rdy) begin
            ok_flag_to_if  <= 1'b0;
            ok_flag_to_lsb <= 1'b0;
            pend_if <= ~drop_flag_from_if &
                       ((pend_if & ~take_if) | ena_from_if);
            pend_ls <= (live_ls & ~take_ls) |
                       (ena_from_lsb & ~rollback_flag_from_rob);
            if (ena_from_if && !drop_flag_from_if) begin
                if_pc <= pc_from_if;
            end
            if (ena_from_lsb && !rollback_flag_from_rob) begin
                ls_wr   <= wr_flag_from_lsb;
                ls_addr <= addr_from_lsb;
                ls_size <= size_from_lsb;
                ls_data <= data_from_lsb;
            end
            unique case (state)
                IDLE: begin
                    if (take_ls) begin
                        mem_a  <= ls_addr;
                        len    <= ls_size;
                        cnt    <= 3'd1;
                        src_ls <= 1'b1;
                        rbuf   <= '0;
                        if (ls_wr) begin
                            state      <= WRITE;
                            mem_wr     <= 1'b1;
                            mem_dout   <= ls_data[7:0];
                            shift_data <= {8'h00, ls_data[31:8]};
                        end else begin
                            state <= READ;
                        end
                    end else if (take_if) begin
                        state  <= READ;
                        mem_a  <= if_pc;
                        len    <= 3'd4;
                        cnt    <= 3'd1;
                        src_ls <= 1'b0;
                        rbuf   <= '0;
                    end
                end
                READ: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < len) begin
                        mem_a <= mem_a + 32'd1;
                    end
                    if (cnt >= 3'd2) begin
                        rbuf <= word;
                    end
                    if (abort) begin
                        state <= IDLE;
                    end else if (done_rd) begin
                        state <= IDLE;
                        if (src_ls) begin
                            ok_flag_to_lsb <= 1'b1;
                            data_to_lsb    <= word;
                        end else begin
                            ok_flag_to_if <= 1'b1;
                            inst_to_if    <= word;
                        end
                    end
                end
                WRITE: begin
                    if (done_wr) begin
                        state          <= IDLE;
                        mem_wr         <= 1'b0;
                        ok_flag_to_lsb <= 1'b1;
                    end else begin
                        mem_a      <= mem_a + 32'd1;
                        mem_dout   <= shift_data[7:0];
                        shift_data <= {8'h00, shift_data[31:8]};
                        cnt        <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte RAM model, reference memory,
// directed corner cases followed by randomized fetch/LSB traffic.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        ena_from_if = 1'b0;
    logic [31:0] pc_from_if = '0;
    logic        drop_flag_from_if = 1'b0;
    logic        ok_flag_to_if;
    logic [31:0] inst_to_if;
    logic        ena_from_lsb = 1'b0;
    logic        wr_flag_from_lsb = 1'b0;
    logic [31:0] addr_from_lsb = '0;
    logic [2:0]  size_from_lsb = '0;
    logic [31:0] data_from_lsb = '0;
    logic        ok_flag_to_lsb;
    logic [31:0] data_to_lsb;
    logic        rollback_flag_from_rob = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ena_from_if(ena_from_if), .pc_from_if(pc_from_if),
        .drop_flag_from_if(drop_flag_from_if),
        .ok_flag_to_if(ok_flag_to_if), .inst_to_if(inst_to_if),
        .ena_from_lsb(ena_from_lsb), .wr_flag_from_lsb(wr_flag_from_lsb),
        .addr_from_lsb(addr_from_lsb), .size_from_lsb(size_from_lsb),
        .data_from_lsb(data_from_lsb), .ok_flag_to_lsb(ok_flag_to_lsb),
        .data_to_lsb(data_to_lsb),
        .rollback_flag_from_rob(rollback_flag_from_rob),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_ok_if = 0;
    int n_ok_ls = 0;
    int n_wr = 0;
    int last_if = 0;
    int last_ls = 0;

    logic [7:0]  ram     [0:262143];
    logic [7:0]  ref_mem [0:262143];
    logic [31:0] q_if[$];
    logic [32:0] q_ls[$];
    logic [39:0] q_wr[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=none exp=event", name);
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a,
                                             input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[8*i +: 8] = ref_mem[18'(a + 32'(i))];
        end
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) ram[mem_a[17:0]] = mem_dout;
        end
    end

    // Monitor: every ok pulse or write beat pops the oldest expectation.
    initial begin
        logic [31:0] ei;
        logic [32:0] el;
        logic [39:0] ew;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ok_flag_to_if) begin
                    n_ok_if = n_ok_if + 1;
                    last_if = cyc;
                    if (q_if.size() == 0) miss("unexpected_ok_if");
                    else begin
                        ei = q_if.pop_front();
                        check("inst_to_if", inst_to_if, ei);
                    end
                end
                if (ok_flag_to_lsb) begin
                    n_ok_ls = n_ok_ls + 1;
                    last_ls = cyc;
                    if (q_ls.size() == 0) miss("unexpected_ok_lsb");
                    else begin
                        el = q_ls.pop_front();
                        if (el[32]) check("data_to_lsb", data_to_lsb, el[31:0]);
                    end
                end
                if (mem_wr) begin
                    n_wr = n_wr + 1;
                    if (q_wr.size() == 0) miss("unexpected_write");
                    else begin
                        ew = q_wr.pop_front();
                        check("wr_addr", mem_a, ew[39:8]);
                        check("wr_data", {24'h0, mem_dout}, {24'h0, ew[7:0]});
                    end
                end
            end
        end
    end

    task automatic pulse_if(input logic [31:0] pc, output int e);
        @(posedge clk); #1;
        ena_from_if = 1'b1;
        pc_from_if  = pc;
        @(posedge clk); #1;
        e = cyc;
        ena_from_if = 1'b0;
    endtask

    task automatic pulse_ls(input logic wr, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] d,
                            output int e);
        @(posedge clk); #1;
        ena_from_lsb     = 1'b1;
        wr_flag_from_lsb = wr;
        addr_from_lsb    = a;
        size_from_lsb    = sz;
        data_from_lsb    = d;
        @(posedge clk); #1;
        e = cyc;
        ena_from_lsb = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, output int e);
        q_if.push_back(exp_word(pc, 4));
        pulse_if(pc, e);
    endtask

    task automatic do_ls(input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] d,
                         output int e);
        if (wr) begin
            for (int i = 0; i < int'(sz); i++) begin
                ref_mem[18'(a + 32'(i))] = d[8*i +: 8];
                q_wr.push_back({a + 32'(i), d[8*i +: 8]});
            end
            q_ls.push_back({1'b0, 32'h0});
        end else begin
            q_ls.push_back({1'b1, exp_word(a, int'(sz))});
        end
        pulse_ls(wr, a, sz, d, e);
    endtask

    task automatic wait_ok(input bit ls, input int bound, input string name);
        int s;
        s = ls ? n_ok_ls : n_ok_if;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if ((ls ? n_ok_ls : n_ok_if) != s) return;
        end
        miss(name);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ok_if"}, {31'h0, ok_flag_to_if}, 32'h0);
        check({tag, "_ok_lsb"}, {31'h0, ok_flag_to_lsb}, 32'h0);
        check({tag, "_inst"}, inst_to_if, 32'h0);
        check({tag, "_data"}, data_to_lsb, 32'h0);
        check({tag, "_mem_a"}, mem_a, 32'h0);
        check({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
        check({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
    endtask

    initial begin
        int e;
        int e2;
        int s;
        logic [31:0] d;

        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            ram[18'h100 + 18'(i)]      = d[7:0];
            ref_mem[18'h100 + 18'(i)]  = d[7:0];
            ram[18'h2000 + 18'(i)]     = d[15:8];
            ref_mem[18'h2000 + 18'(i)] = d[15:8];
        end
        d = 32'h00000513;
        for (int i = 0; i < 4; i++) begin
            ram[18'h100 + 18'(i)]     = d[8*i +: 8];
            ref_mem[18'h100 + 18'(i)] = d[8*i +: 8];
        end

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Fetch: address walk, latency, word assembly.
        do_fetch(32'h100, e);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("fetch_mem_a", mem_a, 32'h100 + 32'(k));
        end
        wait_ok(0, 20, "fetch_ok");
        check("fetch_latency", 32'(last_if - e), 32'd6);

        // Byte store then byte load.
        s = n_wr;
        do_ls(1'b1, 32'h2004, 3'd1, 32'h000000AB, e);
        wait_ok(1, 20, "store_ok");
        check("store_latency", 32'(last_ls - e), 32'd2);
        check("store_beats", 32'(n_wr - s), 32'd1);
        do_ls(1'b0, 32'h2004, 3'd1, 32'h0, e);
        wait_ok(1, 20, "load_ok");
        check("load_latency", 32'(last_ls - e), 32'd3);
        check("load_byte", data_to_lsb, 32'h000000AB);

        // Simultaneous fetch and word load: LSB first.
        q_if.push_back(exp_word(32'h104, 4));
        q_ls.push_back({1'b1, exp_word(32'h2010, 4)});
        @(posedge clk); #1;
        ena_from_if = 1'b1; pc_from_if = 32'h104;
        ena_from_lsb = 1'b1; wr_flag_from_lsb = 1'b0;
        addr_from_lsb = 32'h2010; size_from_lsb = 3'd4;
        @(posedge clk); #1;
        e = cyc;
        ena_from_if = 1'b0; ena_from_lsb = 1'b0;
        wait_ok(1, 20, "both_ls_ok");
        wait_ok(0, 20, "both_if_ok");
        check("both_ls_latency", 32'(last_ls - e), 32'd6);
        check("both_if_latency", 32'(last_if - e), 32'd12);

        // Fetch dropped at edge 3, immediately followed by a new fetch.
        s = n_ok_if;
        pulse_if(32'h108, e);
        repeat (3) @(posedge clk);
        #1 drop_flag_from_if = 1'b1;
        @(posedge clk);
        #1 drop_flag_from_if = 1'b0;
        do_fetch(32'h10C, e2);
        wait_ok(0, 20, "refetch_ok");
        check("drop_ok_count", 32'(n_ok_if - s), 32'd1);
        check("refetch_latency", 32'(last_if - e2), 32'd6);

        // IO store stalled by a full buffer blocks the pending fetch too.
        io_buffer_full = 1'b1;
        q_wr.push_back({32'h30000, 8'h5A});
        q_ls.push_back({1'b0, 32'h0});
        q_if.push_back(exp_word(32'h110, 4));
        @(posedge clk); #1;
        ena_from_if = 1'b1; pc_from_if = 32'h110;
        ena_from_lsb = 1'b1; wr_flag_from_lsb = 1'b1;
        addr_from_lsb = 32'h30000; size_from_lsb = 3'd1;
        data_from_lsb = 32'h5A;
        @(posedge clk); #1;
        e = cyc;
        ena_from_if = 1'b0; ena_from_lsb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_mem_wr", {31'h0, mem_wr}, 32'h0);
            check("stall_mem_a", mem_a, 32'h10F);
        end
        @(posedge clk);
        #1 io_buffer_full = 1'b0;
        @(negedge clk);
        check("stall_release_wr0", {31'h0, mem_wr}, 32'h0);
        @(negedge clk);
        check("stall_release_wr1", {31'h0, mem_wr}, 32'h1);
        check("stall_release_a", mem_a, 32'h30000);
        wait_ok(1, 20, "io_store_ok");
        wait_ok(0, 20, "io_fetch_ok");
        check("io_store_latency", 32'(last_ls - e), 32'd6);
        check("io_fetch_latency", 32'(last_if - e), 32'd12);

        // Rollback during a load: no completion.
        s = n_ok_ls;
        pulse_ls(1'b0, 32'h2020, 3'd4, 32'h0, e);
        repeat (2) @(posedge clk);
        #1 rollback_flag_from_rob = 1'b1;
        @(posedge clk);
        #1 rollback_flag_from_rob = 1'b0;
        repeat (8) @(posedge clk);
        check("rollback_no_ok", 32'(n_ok_ls - s), 32'h0);

        // Rollback during a store: the store still completes.
        d = $urandom;
        do_ls(1'b1, 32'h2030, 3'd4, d, e);
        @(posedge clk);
        #1 rollback_flag_from_rob = 1'b1;
        @(posedge clk);
        #1 rollback_flag_from_rob = 1'b0;
        wait_ok(1, 20, "rb_store_ok");
        check("rb_store_latency", 32'(last_ls - e), 32'd5);
        do_ls(1'b0, 32'h2030, 3'd4, 32'h0, e);
        wait_ok(1, 20, "rb_load_ok");
        check("rb_load_word", data_to_lsb, d);

        // Reset in the middle of a word store.
        do_ls(1'b1, 32'h8000, 3'd4, 32'hDEADBEEF, e);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("midrst");
        q_wr.delete();
        q_ls.delete();
        rst = 1'b0;
        do_fetch(32'h120, e);
        wait_ok(0, 20, "post_rst_fetch");
        check("post_rst_latency", 32'(last_if - e), 32'd6);

        // Randomized traffic from both sources.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    automatic int ef;
                    automatic logic [31:0] pc = 32'h100 + $urandom_range(0, 252);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_fetch(pc, ef);
                    wait_ok(0, 40, "rnd_fetch_ok");
                end
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    automatic int el;
                    automatic int r = $urandom_range(0, 2);
                    automatic logic [2:0] sz = (r == 0) ? 3'd1 :
                                               (r == 1) ? 3'd2 : 3'd4;
                    automatic logic [31:0] a = 32'h2000 + $urandom_range(0, 248);
                    automatic logic [31:0] wd = $urandom;
                    automatic logic wr = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_ls(wr, a, sz, wd, el);
                    wait_ok(1, 40, "rnd_lsb_ok");
                end
            end
        join

        repeat (10) @(posedge clk);
        check("q_if_empty", 32'(q_if.size()), 32'h0);
        check("q_ls_empty", 32'(q_ls.size()), 32'h0);
        check("q_wr_empty", 32'(q_wr.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the instruction fetcher, the load/store buffer (LSB) and the single-port 8-bit RAM/IO bus. It arbitrates fetcher instruction reads and LSB loads and stores, gives LSB priority, and assembles or splits little-endian words one byte per cycle. It also honours the fetcher's drop request, ROB rollback and the IO buffer full flag.

## Interface
- No parameters. Word = 32 bits, address = 32 bits, IO region = addr[17:16] == 2'b11.
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- rdy  in  1  chip ready; low freezes all state and outputs
- ena_from_if  in  1  one-cycle fetch request pulse
- pc_from_if  in  32  fetch address
- drop_flag_from_if  in  1  cancel pending or in-flight fetch
- ok_flag_to_if  out  1  one-cycle pulse; inst_to_if is valid
- inst_to_if  out  32  fetched word
- ena_from_lsb  in  1  one-cycle load/store request pulse
- wr_flag_from_lsb  in  1  1 = store, 0 = load
- addr_from_lsb  in  32  byte address
- size_from_lsb  in  3  byte count; must be 1, 2 or 4
- data_from_lsb  in  32  store data (low bytes used)
- ok_flag_to_lsb  out  1  one-cycle completion pulse
- data_to_lsb  out  32  load data, zero-extended
- rollback_flag_from_rob  in  1  cancel a pending or in-flight LSB load
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write

## Operation
- Request latching:
  - Accepted ena pulses set pending_if / pending_ls and latch address, size, data and wr.
  - A pulse arriving while the same source is already pending is a protocol error and is not checked.
- States: IDLE, READ, WRITE.
- IDLE arbitration, evaluated every cycle:
  - pending_ls has priority over pending_if.
  - A fetch is always a 4-byte read.
  - An IO store with io_buffer_full = 1 waits in IDLE. The fetch is not served in its place; LSB priority holds.
- READ, N bytes:
  - Byte k is captured from mem_din into byte lane k.
  - mem_a walks base, base+1, …, base+N-1.
  - After the last capture: pulse the source's ok flag, drive the data output, return to IDLE.
- WRITE, N bytes:
  - mem_wr = 1, mem_a = base+k, mem_dout = byte k of the data, for k = 0..N-1.
  - Then mem_wr <= 0, pulse ok_flag_to_lsb, return to IDLE.
- drop_flag_from_if:
  - Clears pending_if.
  - If a fetch is in READ, aborts it: IDLE on the next edge, no ok pulse.
  - Has priority over a same-cycle ena_from_if; that ena is ignored.
- rollback_flag_from_rob:
  - Clears a pending load and aborts an in-flight load the same way.
  - Pending and in-flight stores are unaffected; they were committed.
  - Simultaneous ena_from_lsb is ignored.
- Completion vs. abort on the same edge: abort wins; no ok pulse.
- Address arithmetic is 32-bit wrap-around.
- rst mid-transfer: everything is abandoned.
- Reset values: state IDLE, pending flags 0, mem_a 0, mem_dout 0, mem_wr 0, ok flags 0, inst_to_if 0, data_to_lsb 0.

## Timing
- Edge 0 is the edge at which IDLE accepts a request. At edge 0: mem_a <= base.
- Read timing:
  - Edge k, 1 ≤ k < N: mem_a <= base+k.
  - Edge k+2: captures byte k, because RAM read data lags its address by one cycle.
  - ok is high in the cycle after edge N+1. A 4-byte fetch gives ok after edge 5; a 1-byte load after edge 2.
- Write timing: mem_wr high during cycles 0..N-1; ok high in the cycle after edge N.
- Back-to-back:
  - ok and the return to IDLE share an edge.
  - The next arbitration happens in the cycle after that edge.
  - A request pulse may arrive in the same cycle its ok pulse is seen.
- ok pulses last exactly one cycle. Data outputs hold until the next completion.
- mem_wr is never high in READ or IDLE.

## Test plan
- Fetch:
  - Stimulus: RAM[0x100..0x103] = 13 05 00 00; ena_from_if at pc 0x100.
  - Required: mem_a 0x100..0x103; ok_flag_to_if after edge 5; inst_to_if = 0x00000513.
- Byte store, then byte load:
  - Stimulus: store size 1, data 0xAB to 0x2004, then load size 1 from 0x2004.
  - Required: one write cycle; load returns data_to_lsb = 0x000000AB.
- Same-cycle requests:
  - Stimulus: ena_from_if and a 4-byte LSB load arrive together.
  - Required: the load completes first (ok after edge 5); the fetch starts the next cycle and completes 6 cycles later.
- Fetch drop:
  - Stimulus: drop_flag_from_if asserted at edge 3 of a fetch.
  - Required: no ok_flag_to_if; IDLE after edge 3; a new fetch next cycle returns the correct word.
- IO store stall:
  - Stimulus: store to 0x30000 while io_buffer_full = 1 for 4 cycles, with a fetch also pending.
  - Required: mem_wr stays 0 and no fetch is issued; the write starts the cycle after full drops.
- Rollback and reset:
  - Stimulus: rollback_flag_from_rob during a load; separately, rst mid-store.
  - Required: the load gets no ok. After reset, all outputs are zero and state is IDLE.
